// File: rtl/hdmi_rx_pkg.sv
// ============================================================================
// hdmi_rx_pkg
// Shared TMDS receive-side constants: the four control tokens and the
// aligner state encoding.
// Rev 1.0
// ============================================================================
`default_nettype none

package hdmi_rx_pkg;

  localparam logic [9:0] TMDS_CTRL_00 = 10'b1101010100;
  localparam logic [9:0] TMDS_CTRL_01 = 10'b0010101011;
  localparam logic [9:0] TMDS_CTRL_10 = 10'b0101010100;
  localparam logic [9:0] TMDS_CTRL_11 = 10'b1010101011;

  typedef enum logic [0:0] {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } align_state_t;

endpackage

`default_nettype wire

// File: rtl/hdmi_token_detect.sv
// ============================================================================
// hdmi_token_detect
// Combinational match of a 10-bit TMDS word against the four control tokens.
// Rev 1.0
// ============================================================================
`default_nettype none

module hdmi_token_detect
  import hdmi_rx_pkg::*;
(
  input  logic [9:0] word,
  output logic       is_ctrl,
  output logic [1:0] ctrl
);

  always_comb begin
    is_ctrl = 1'b1;
    ctrl    = 2'b00;
    case (word)
      TMDS_CTRL_00: ctrl = 2'b00;
      TMDS_CTRL_01: ctrl = 2'b01;
      TMDS_CTRL_10: ctrl = 2'b10;
      TMDS_CTRL_11: ctrl = 2'b11;
      default:      is_ctrl = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/hdmi_word_aligner.sv
// ============================================================================
// hdmi_word_aligner
// Rebuilds 10-bit TMDS words from 5-bit nibbles and bit-slips until control
// tokens appear consistently, then reports lock.
// Rev 1.0
// ============================================================================
`default_nettype none

module hdmi_word_aligner
  import hdmi_rx_pkg::*;
#(
  parameter int LOCK_HITS    = 8,
  parameter int SEARCH_WORDS = 2048,
  parameter int LOSS_WORDS   = 4096
) (
  input  logic       gclk,
  input  logic       rst,
  input  logic [4:0] d,
  input  logic       d_valid,
  output logic [9:0] word,
  output logic       word_valid,
  output logic       is_ctrl,
  output logic [1:0] ctrl,
  output logic       locked,
  output logic [3:0] offset
);

  localparam int MAX_AB = (LOCK_HITS > SEARCH_WORDS) ? LOCK_HITS : SEARCH_WORDS;
  localparam int MAX_P  = (MAX_AB > LOSS_WORDS) ? MAX_AB : LOSS_WORDS;
  localparam int CW     = $clog2(MAX_P + 1);

  localparam logic [CW-1:0] C_LOCK   = CW'(LOCK_HITS);
  localparam logic [CW-1:0] C_SEARCH = CW'(SEARCH_WORDS);
  localparam logic [CW-1:0] C_LOSS   = CW'(LOSS_WORDS);

  // Only the upper 15 bits of the 20-bit window survive to the next shift,
  // so the lowest nibble is never stored.
  logic [14:0]    hist_q, hist_d;
  logic           phase_q, phase_d;
  align_state_t   state_q, state_d;
  logic [CW-1:0]  hit_q, hit_d;
  logic [CW-1:0]  miss_q, miss_d;
  logic [3:0]     offset_q, offset_d;
  logic [9:0]     word_q, word_d;
  logic           word_valid_q, word_valid_d;
  logic           is_ctrl_q, is_ctrl_d;
  logic [1:0]     ctrl_q, ctrl_d;
  logic           locked_q, locked_d;

  logic [19:0]    buf_next;
  logic [9:0]     win [10];
  logic [9:0]     cand;
  logic           cand_is_ctrl;
  logic [1:0]     cand_ctrl;
  logic [CW-1:0]  hit_inc, miss_inc;

  assign buf_next = {d, hist_q};

  for (genvar i = 0; i < 10; i++) begin : g_win
    assign win[i] = buf_next[i +: 10];
  end

  assign cand = (offset_q <= 4'd9) ? win[offset_q] : win[0];

  hdmi_token_detect u_token_detect (
    .word    (cand),
    .is_ctrl (cand_is_ctrl),
    .ctrl    (cand_ctrl)
  );

  assign hit_inc  = (hit_q  == {CW{1'b1}}) ? hit_q  : hit_q  + 1'b1;
  assign miss_inc = (miss_q == {CW{1'b1}}) ? miss_q : miss_q + 1'b1;

  always_comb begin
    hist_d       = hist_q;
    phase_d      = phase_q;
    state_d      = state_q;
    hit_d        = hit_q;
    miss_d       = miss_q;
    offset_d     = offset_q;
    word_d       = word_q;
    word_valid_d = 1'b0;
    is_ctrl_d    = is_ctrl_q;
    ctrl_d       = ctrl_q;
    locked_d     = locked_q;

    if (d_valid) begin
      hist_d  = buf_next[19:5];
      phase_d = ~phase_q;
      if (phase_q) begin
        word_d       = cand;
        word_valid_d = 1'b1;
        is_ctrl_d    = cand_is_ctrl;
        ctrl_d       = cand_ctrl;
        case (state_q)
          ST_SEARCH: begin
            if (cand_is_ctrl) begin
              // A token wins over an expiring miss count: no slip here.
              miss_d = '0;
              if (hit_inc >= C_LOCK) begin
                state_d  = ST_LOCKED;
                locked_d = 1'b1;
                hit_d    = '0;
              end else begin
                hit_d = hit_inc;
              end
            end else begin
              hit_d = '0;
              if (miss_inc >= C_SEARCH) begin
                miss_d   = '0;
                offset_d = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
              end else begin
                miss_d = miss_inc;
              end
            end
          end
          ST_LOCKED: begin
            hit_d = '0;
            if (cand_is_ctrl) begin
              miss_d = '0;
            end else if (miss_inc >= C_LOSS) begin
              // Offset is kept so the new search starts from the last good one.
              state_d  = ST_SEARCH;
              locked_d = 1'b0;
              miss_d   = '0;
            end else begin
              miss_d = miss_inc;
            end
          end
          default: begin
            state_d  = ST_SEARCH;
            locked_d = 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge gclk) begin
    if (rst) begin
      hist_q       <= '0;
      phase_q      <= 1'b0;
      state_q      <= ST_SEARCH;
      hit_q        <= '0;
      miss_q       <= '0;
      offset_q     <= 4'd0;
      word_q       <= 10'd0;
      word_valid_q <= 1'b0;
      is_ctrl_q    <= 1'b0;
      ctrl_q       <= 2'b00;
      locked_q     <= 1'b0;
    end else begin
      hist_q       <= hist_d;
      phase_q      <= phase_d;
      state_q      <= state_d;
      hit_q        <= hit_d;
      miss_q       <= miss_d;
      offset_q     <= offset_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      is_ctrl_q    <= is_ctrl_d;
      ctrl_q       <= ctrl_d;
      locked_q     <= locked_d;
    end
  end

  assign word       = word_q;
  assign word_valid = word_valid_q;
  assign is_ctrl    = is_ctrl_q;
  assign ctrl       = ctrl_q;
  assign locked     = locked_q;
  assign offset     = offset_q;

endmodule

`default_nettype wire

// File: tb/tb_hdmi_word_aligner.sv
// ============================================================================
// tb_hdmi_word_aligner
// Randomised-gap stimulus against a bit-history reference model of the aligner.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_hdmi_word_aligner;

  localparam int LOCK_HITS    = 8;
  localparam int SEARCH_WORDS = 16;
  localparam int LOSS_WORDS   = 32;

  localparam logic [9:0] TOK00 = 10'b1101010100;
  localparam logic [9:0] TOK01 = 10'b0010101011;
  localparam logic [9:0] TOK10 = 10'b0101010100;
  localparam logic [9:0] TOK11 = 10'b1010101011;
  localparam logic [9:0] DATA  = 10'h1F0;

  logic       gclk = 1'b0;
  logic       rst;
  logic [4:0] d;
  logic       d_valid;
  logic [9:0] word;
  logic       word_valid;
  logic       is_ctrl;
  logic [1:0] ctrl;
  logic       locked;
  logic [3:0] offset;

  always #5 gclk = ~gclk;

  hdmi_word_aligner #(
    .LOCK_HITS    (LOCK_HITS),
    .SEARCH_WORDS (SEARCH_WORDS),
    .LOSS_WORDS   (LOSS_WORDS)
  ) dut (
    .gclk       (gclk),
    .rst        (rst),
    .d          (d),
    .d_valid    (d_valid),
    .word       (word),
    .word_valid (word_valid),
    .is_ctrl    (is_ctrl),
    .ctrl       (ctrl),
    .locked     (locked),
    .offset     (offset)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: full received-bit history since reset; word k is the
  // ten bits starting (20 - offset) bits back from the newest one.
  bit         rx[$];
  bit         tx[$];
  int         m_phase, m_off, m_hit, m_miss;
  bit         m_locked, m_wv, m_isc;
  logic [9:0] m_word;
  logic [1:0] m_ctrl;
  bit         gaps_on;

  function automatic void tok_lookup(input logic [9:0] w, output bit isc, output logic [1:0] c);
    isc = 1'b1;
    c   = 2'b00;
    if      (w == TOK00) c = 2'b00;
    else if (w == TOK01) c = 2'b01;
    else if (w == TOK10) c = 2'b10;
    else if (w == TOK11) c = 2'b11;
    else                 isc = 1'b0;
  endfunction

  task automatic model_clock(input bit r, input bit v, input logic [4:0] nib);
    int start;
    int idx;
    if (r) begin
      rx.delete();
      m_phase = 0; m_off = 0; m_hit = 0; m_miss = 0;
      m_locked = 0; m_wv = 0; m_isc = 0; m_word = '0; m_ctrl = '0;
      return;
    end
    m_wv = 0;
    if (!v) return;
    for (int j = 0; j < 5; j++) rx.push_back(nib[j]);
    if (m_phase == 0) begin
      m_phase = 1;
      return;
    end
    m_phase = 0;
    start = rx.size() - 20 + m_off;
    for (int j = 0; j < 10; j++) begin
      idx = start + j;
      m_word[j] = (idx >= 0) ? rx[idx] : 1'b0;
    end
    m_wv = 1;
    tok_lookup(m_word, m_isc, m_ctrl);
    if (!m_locked) begin
      if (m_isc) begin
        m_hit++;
        m_miss = 0;
        if (m_hit == LOCK_HITS) begin m_locked = 1; m_hit = 0; end
      end else begin
        m_hit = 0;
        m_miss++;
        if (m_miss == SEARCH_WORDS) begin m_off = (m_off + 1) % 10; m_miss = 0; end
      end
    end else begin
      if (m_isc) m_miss = 0;
      else begin
        m_miss++;
        if (m_miss == LOSS_WORDS) begin m_locked = 0; m_miss = 0; end
      end
    end
  endtask

  task automatic step(input bit r, input bit v, input logic [4:0] nib);
    @(negedge gclk);
    rst = r; d_valid = v; d = nib;
    @(posedge gclk);
    model_clock(r, v, nib);
    #1;
    check_eq("word_valid", {31'd0, word_valid}, {31'd0, m_wv});
    check_eq("locked", {31'd0, locked}, {31'd0, m_locked});
    check_eq("offset", {28'd0, offset}, m_off);
    if (m_wv) begin
      check_eq("word", {22'd0, word}, {22'd0, m_word});
      check_eq("is_ctrl", {31'd0, is_ctrl}, {31'd0, m_isc});
      check_eq("ctrl", {30'd0, ctrl}, {30'd0, m_ctrl});
    end
  endtask

  task automatic push_word(input logic [9:0] w);
    for (int j = 0; j < 10; j++) tx.push_back(w[j]);
  endtask

  task automatic drain();
    logic [4:0] nib;
    while (tx.size() >= 5) begin
      if (gaps_on && $urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 3)) step(1'b0, 1'b0, 5'($urandom));
      for (int j = 0; j < 5; j++) nib[j] = tx.pop_front();
      step(1'b0, 1'b1, nib);
    end
  endtask

  task automatic do_reset();
    step(1'b1, 1'b1, 5'($urandom));
    check_eq("rst_word", {22'd0, word}, 32'd0);
    check_eq("rst_word_valid", {31'd0, word_valid}, 32'd0);
    check_eq("rst_is_ctrl", {31'd0, is_ctrl}, 32'd0);
    check_eq("rst_ctrl", {30'd0, ctrl}, 32'd0);
    check_eq("rst_locked", {31'd0, locked}, 32'd0);
    check_eq("rst_offset", {28'd0, offset}, 32'd0);
    step(1'b1, 1'b0, 5'd0);
    tx.delete();
  endtask

  initial begin
    rst = 1'b1; d = '0; d_valid = 1'b0; gaps_on = 1'b1;
    do_reset();

    // Aligned locking at offset 0
    repeat (12) push_word(TOK00);
    drain();
    check_eq("aligned_locked", {31'd0, locked}, 32'd1);
    check_eq("aligned_offset", {28'd0, offset}, 32'd0);

    // Loss of lock: 31 tokenless words keep lock, the 32nd drops it
    repeat (32) push_word(DATA);
    drain();
    check_eq("loss_hold", {31'd0, locked}, 32'd1);
    push_word(DATA);
    drain();
    check_eq("loss_fall", {31'd0, locked}, 32'd0);
    check_eq("loss_offset_kept", {28'd0, offset}, 32'd0);
    repeat (10) push_word(TOK00);
    drain();
    check_eq("relock", {31'd0, locked}, 32'd1);

    // Reset while locked, then slip search with stream delayed by 3 bits
    do_reset();
    repeat (3) tx.push_back(1'b0);
    repeat (75) push_word(TOK00);
    drain();
    check_eq("slip_offset", {28'd0, offset}, 32'd3);
    check_eq("slip_locked", {31'd0, locked}, 32'd1);

    // Token on the expiring word counts as hit; a non-token breaks a run of 7
    do_reset();
    repeat (14) push_word(DATA);
    repeat (2) push_word(TOK00);
    drain();
    check_eq("expiry_no_slip", {28'd0, offset}, 32'd0);
    repeat (5) push_word(TOK00);
    push_word(DATA);
    repeat (8) push_word(TOK00);
    drain();
    check_eq("seven_hits_unlocked", {31'd0, locked}, 32'd0);
    push_word(DATA);
    drain();
    check_eq("eighth_hit_locks", {31'd0, locked}, 32'd1);

    // Random words with random gaps
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 5))
        0: push_word(TOK00);
        1: push_word(TOK01);
        2: push_word(TOK10);
        3: push_word(TOK11);
        default: push_word(10'($urandom));
      endcase
    end
    drain();

    // Offset wrap through 9 back to 0, then all four tokens
    do_reset();
    repeat (145) push_word(DATA);
    drain();
    check_eq("offset_nine", {28'd0, offset}, 32'd9);
    repeat (16) push_word(DATA);
    drain();
    check_eq("offset_wrap", {28'd0, offset}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      push_word(TOK00); push_word(TOK01); push_word(TOK10); push_word(TOK11);
    end
    push_word(DATA);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
